// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants (active-low {g,f,e,d,c,b,a}) and the hex-to-glyph
// lookup shared by every display block.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/adder_hex_scan_display_if.sv
// Operand/strobe inputs and board-pin outputs of the adder display.
// master = the side feeding operands, slave = the display block.
interface adder_hex_scan_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = WIDTH / 4 + 1
);
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              load;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              cout;
  logic              valid;

  modport master (
    output a, b, cin, load,
    input  seg, an, cout, valid
  );

  modport slave (
    input  a, b, cin, load,
    output seg, an, cout, valid
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder; chained WIDTH times to form the ripple-carry sum.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/adder_hex_scan_display.sv
// Registered ripple-carry adder whose sum and carry are scanned one active-low
// anode at a time onto a multi-digit hex seven-segment display.
module adder_hex_scan_display
  import seg7_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 0
) (
  input logic                      clk,
  input logic                      rst,
  adder_hex_scan_display_if.slave  bus
);

  localparam int DIGITS = WIDTH / 4 + 1;
  localparam int PW     = $clog2(REFRESH_DIV);
  localparam int DW     = $clog2(DIGITS);

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 32 || REFRESH_DIV < 2) begin : g_param_check
    $error("adder_hex_scan_display: WIDTH must be a multiple of 4 in 4..32 and REFRESH_DIV >= 2");
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (carry[i]),
      .s  (sum_bits[i]),
      .co (carry[i+1])
    );
  end

  // ---- stage p1: captured result and its valid pulse ----
  logic [WIDTH:0] r_p1;
  logic           vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.load;
      if (bus.load) begin
        r_p1 <= {carry[WIDTH], sum_bits};
      end
    end
  end

  logic [PW-1:0] p_q;
  logic [DW-1:0] d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      d_q <= '0;
    end else if (p_q == PW'(REFRESH_DIV - 1)) begin
      p_q <= '0;
      d_q <= (d_q == DW'(DIGITS - 1)) ? '0 : d_q + DW'(1);
    end else begin
      p_q <= p_q + PW'(1);
    end
  end

  // Carry digit is a zero-padded nibble so every digit selects uniformly.
  logic [4*DIGITS-1:0] rx;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          dig_sel;
  logic [6:0]          seg_nxt;
  logic [DIGITS-1:0]   an_nxt;

  assign rx = {3'b000, r_p1};

  always_comb begin : blank_calc
    logic nz;
    nz    = 1'b0;
    blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz       = nz | (rx[4*i +: 4] != 4'h0);
      blank[i] = (BLANK_LZ != 0) && (i != 0) && !nz;
    end
  end

  always_comb begin
    dig_sel = rx[{d_q, 2'b00} +: 4];
    seg_nxt = blank[d_q] ? SEG_BLANK : hex_glyph(dig_sel);
    an_nxt  = '1;
    an_nxt[d_q] = 1'b0;
  end

  // ---- stage p2: anode and segment pins, always updated together ----
  logic [6:0]        seg_p2;
  logic [DIGITS-1:0] an_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p2 <= SEG_0;
      an_p2  <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      seg_p2 <= seg_nxt;
      an_p2  <= an_nxt;
    end
  end

  assign bus.seg   = seg_p2;
  assign bus.an    = an_p2;
  assign bus.cout  = r_p1[WIDTH];
  assign bus.valid = vld_p1;

endmodule
